// File: rtl/gray_track_ctrl_pkg.sv
// Shared definitions for the Gray-code position tracker: FSM state encoding.
package gray_track_ctrl_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/gray_to_bin_n.sv
// Combinational W-bit Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits from the MSB down to that position.
module gray_to_bin_n #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/gray_track_ctrl.sv
// Tracks an asynchronous Gray-coded position: synchronises, converts, classifies each
// change as up/down/illegal and hands it to a binary consumer over valid/ready.
module gray_track_ctrl
  import gray_track_ctrl_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr_err,
  input  logic [W-1:0]    g_in,
  output logic [W-1:0]    b_out,
  output logic            b_valid,
  input  logic            b_ready,
  output logic            dir,
  output logic            step_err,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [W-1:0]    DeltaUp   = W'(1);
  localparam logic [W-1:0]    DeltaDown = {W{1'b1}};
  localparam logic [ERRW-1:0] CntMax    = {ERRW{1'b1}};

  logic [W-1:0]    s1_q, s2_q;
  logic [W-1:0]    bin_s, bin_q, delta;
  logic [W-1:0]    b_out_q;
  logic            b_valid_q, dir_q, step_err_q;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            capture, cap_err;
  state_e          state_q;

  // Two-flop synchroniser; Gray coding keeps a mid-transition sample within one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= g_in;
      s2_q <= s1_q;
    end
  end

  gray_to_bin_n #(
    .W(W)
  ) u_g2b (
    .gray_i(s2_q),
    .bin_o (bin_s)
  );

  assign delta   = bin_s - bin_q;
  assign capture = (state_q == StTrack) && en && (delta != '0);
  assign cap_err = (delta != DeltaUp) && (delta != DeltaDown);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      b_out_q    <= '0;
      b_valid_q  <= 1'b0;
      dir_q      <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Baseline follows the input so that enabling never reports stale movement.
          bin_q <= bin_s;
          if (en) state_q <= StTrack;
        end
        StTrack: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (capture) begin
            b_out_q    <= bin_s;
            bin_q      <= bin_s;
            b_valid_q  <= 1'b1;
            dir_q      <= (delta == DeltaUp);
            step_err_q <= cap_err;
            state_q    <= StHold;
          end
        end
        StHold: begin
          // Movement during HOLD accumulates against the frozen baseline.
          if (b_valid_q && b_ready) begin
            b_valid_q  <= 1'b0;
            step_err_q <= 1'b0;
            state_q    <= en ? StTrack : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (capture && cap_err && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign b_out    = b_out_q;
  assign b_valid  = b_valid_q;
  assign dir      = dir_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_track_ctrl.sv
// Self-checking bench for gray_track_ctrl: vector table plus directed corner sequences,
// with a scoreboard of expected events popped at each valid/ready handshake.
module tb_gray_track_ctrl;

  localparam int unsigned W    = 4;
  localparam int unsigned ERRW = 2;

  logic            clk = 1'b0;
  logic            rst_n, en, clr_err, b_ready;
  logic [W-1:0]    g_in, b_out;
  logic            b_valid, dir, step_err;
  logic [ERRW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] b;
    logic         d;
    logic         se;
  } exp_t;

  typedef struct {
    logic [W-1:0]    g;
    logic            ev;
    logic [W-1:0]    b;
    logic            d;
    logic            se;
    logic [ERRW-1:0] cnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  gray_track_ctrl #(
    .W   (W),
    .ERRW(ERRW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr_err (clr_err),
    .g_in    (g_in),
    .b_out   (b_out),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .dir     (dir),
    .step_err(step_err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] b, input logic d, input logic se);
    exp_t e;
    e.b  = b;
    e.d  = d;
    e.se = se;
    sb_q.push_back(e);
  endtask

  // Handshake completes on the next rising edge; sample on the falling edge before it.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && b_valid && b_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got b_out=%0h dir=%0b step_err=%0b expected none",
                   b_out, dir, step_err);
        end else begin
          e = sb_q.pop_front();
          chk("ev_b_out", 32'(b_out), 32'(e.b));
          chk("ev_dir", 32'(dir), 32'(e.d));
          chk("ev_step_err", 32'(step_err), 32'(e.se));
        end
      end
    end
  endtask

  task automatic lat_step(input logic [W-1:0] g, input logic [W-1:0] b);
    int n;
    push(b, 1'b1, 1'b0);
    g_in = g;
    n = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (b_valid) begin
        n = i;
        break;
      end
    end
    chk("latency_edges", 32'(n), 32'd3);
    tick(3);
  endtask

  initial begin
    vecs[0]  = '{4'b0110, 1'b1, 4'd4,  1'b1, 1'b0, 2'd0};
    vecs[1]  = '{4'b0111, 1'b1, 4'd5,  1'b1, 1'b0, 2'd0};
    vecs[2]  = '{4'b0110, 1'b1, 4'd4,  1'b0, 1'b0, 2'd0};
    vecs[3]  = '{4'b0010, 1'b1, 4'd3,  1'b0, 1'b0, 2'd0};
    vecs[4]  = '{4'b0010, 1'b0, 4'd0,  1'b0, 1'b0, 2'd0};
    vecs[5]  = '{4'b1000, 1'b1, 4'd15, 1'b0, 1'b1, 2'd1};
    vecs[6]  = '{4'b0000, 1'b1, 4'd0,  1'b1, 1'b0, 2'd1};
    vecs[7]  = '{4'b1000, 1'b1, 4'd15, 1'b0, 1'b0, 2'd1};
    vecs[8]  = '{4'b0000, 1'b1, 4'd0,  1'b1, 1'b0, 2'd1};
    vecs[9]  = '{4'b0110, 1'b1, 4'd4,  1'b0, 1'b1, 2'd2};
    vecs[10] = '{4'b0000, 1'b1, 4'd0,  1'b0, 1'b1, 2'd3};
    vecs[11] = '{4'b0110, 1'b1, 4'd4,  1'b0, 1'b1, 2'd3};
    vecs[12] = '{4'b0000, 1'b1, 4'd0,  1'b0, 1'b1, 2'd3};

    rst_n   = 1'b0;
    en      = 1'b0;
    clr_err = 1'b0;
    b_ready = 1'b0;
    g_in    = '0;
    fork
      monitor();
    join_none

    #3;
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    #20;
    rst_n = 1'b1;
    tick(2);

    en      = 1'b1;
    b_ready = 1'b1;
    tick(4);
    lat_step(4'b0001, 4'd1);
    lat_step(4'b0011, 4'd2);
    lat_step(4'b0010, 4'd3);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].ev) push(vecs[i].b, vecs[i].d, vecs[i].se);
      g_in = vecs[i].g;
      tick(5);
      chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].cnt));
    end

    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Clear coincides with an erroneous capture on the third edge.
    push(4'd4, 1'b0, 1'b1);
    g_in = 4'b0110;
    @(posedge clk);
    @(posedge clk);
    #2;
    clr_err = 1'b1;
    @(posedge clk);
    #2;
    clr_err = 1'b0;
    tick(3);
    chk("clr_priority_err_cnt", 32'(err_cnt), 32'd0);

    // Backpressure: movement 5->6->7 while held merges into one delta=2 event.
    b_ready = 1'b0;
    push(4'd5, 1'b1, 1'b0);
    g_in = 4'b0111;
    tick(5);
    chk("bp_valid_held", 32'(b_valid), 32'd1);
    chk("bp_b_out_held", 32'(b_out), 32'd5);
    g_in = 4'b0101;
    tick(3);
    g_in = 4'b0100;
    tick(5);
    chk("bp_valid_still", 32'(b_valid), 32'd1);
    chk("bp_b_out_frozen", 32'(b_out), 32'd5);
    push(4'd7, 1'b0, 1'b1);
    b_ready = 1'b1;
    tick(6);
    chk("bp_err_cnt", 32'(err_cnt), 32'd1);

    // Disable during HOLD: handshake still completes, then idle rebaselines.
    b_ready = 1'b0;
    push(4'd6, 1'b0, 1'b0);
    g_in = 4'b0101;
    tick(5);
    en = 1'b0;
    tick(2);
    chk("en_off_valid_kept", 32'(b_valid), 32'd1);
    b_ready = 1'b1;
    tick(3);
    chk("en_off_valid_done", 32'(b_valid), 32'd0);
    g_in = 4'b0111;
    tick(4);
    g_in = 4'b0110;
    tick(4);
    chk("idle_no_event", 32'(b_valid), 32'd0);
    en = 1'b1;
    tick(4);
    chk("reenable_no_event", 32'(b_valid), 32'd0);
    push(4'd3, 1'b0, 1'b0);
    g_in = 4'b0010;
    tick(5);

    // Asynchronous reset while an event is pending.
    b_ready = 1'b0;
    g_in = 4'b0011;
    tick(5);
    chk("pre_rst_valid", 32'(b_valid), 32'd1);
    chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(b_valid), 32'd0);
    chk("async_rst_b_out", 32'(b_out), 32'd0);
    chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    #3;
    rst_n = 1'b1;
    tick(3);
    b_ready = 1'b1;
    tick(3);
    chk("post_rst_valid", 32'(b_valid), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_track_ctrl.md
Name: gray_track_ctrl

Overview:
- Sequencer wrapped around a parameterised Gray-to-binary converter. It tracks a Gray-coded position or pointer arriving from an asynchronous source, such as an encoder or a remote-domain FIFO pointer.
- Each legal single-step change is synchronised, converted, classified (up or down) and delivered through a valid/ready handshake.
- Illegal multi-bit jumps are flagged and counted.
- Sits between raw Gray inputs and downstream binary consumers (counters, FIFO flag logic).

Parameters:
W, 4, Gray/binary word width (>=2)
ERRW, 8, error-counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  tracking enable
clr_err  input  1  synchronous clear of err_cnt
g_in  input  W  asynchronous Gray-coded input
b_out  output  W  registered binary value of last accepted change
b_valid  output  1  b_out/dir/step_err are valid
b_ready  input  1  consumer accepts when b_valid&b_ready
dir  output  1  1 = increment (+1 mod 2^W), 0 = decrement
step_err  output  1  accepted change was not ±1 (qualified by b_valid)
err_cnt  output  ERRW  saturating count of step errors

Behaviour:
- Reset (async, rst_n=0): sync stages s1/s2=0, baseline bin_q=0, b_out=0, b_valid=0, dir=0, step_err=0, err_cnt=0, state=IDLE.
- Synchroniser: g_in->s1->s2, two flops, always running.
- Conversion: bin_s = gray_to_bin_n(s2), combinational; bit i = XOR of s2[W-1:i].
- delta = (bin_s - bin_q) mod 2^W, W bits.
- FSM states:
  - IDLE: bin_q <= bin_s every cycle (baseline follows input, no events). en=1 -> TRACK.
  - TRACK:
    - en=0 -> IDLE.
    - else if delta!=0: capture. b_out<=bin_s, bin_q<=bin_s, b_valid<=1, dir<=(delta==1). step_err<=(delta!=1 && delta!={W{1}}). -> HOLD.
    - A capture with step_err=1 increments err_cnt unless err_cnt is all ones (saturate).
  - HOLD: outputs frozen. b_valid&b_ready -> b_valid<=0, step_err<=0. Next state is TRACK if en=1, else IDLE.
- en falling while in HOLD does not abort the handshake. The FSM completes the handshake, then goes to IDLE.
- Latency: g_in change stable before edge E0 -> b_valid high after edge E2 (2 sync + 1 capture). Earliest next capture is the cycle after the handshake.
- Changes during HOLD are not lost. The comparison resumes against bin_q after HOLD, so accumulated movement appears as one event. It is flagged step_err if not ±1.
- Wrap-around: bin {W{1}} -> 0 is delta=1 (up, no error). 0 -> {W{1}} is delta={W{1}} (down, no error).
- Entering TRACK from IDLE never raises a spurious event, because the baseline equals the current value.
- clr_err has priority over an increment in the same cycle: the result is 0.
- Reset mid-HOLD drops b_valid immediately, with no handshake.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, TRACK=2'd1, HOLD=2'd2.
- Sub-module gray_to_bin_n: parameter W, purely combinational XOR-prefix converter, instantiated once on s2.
- Synchroniser, baseline, FSM and counter live in gray_track_ctrl.

Test Plan:
- Reset then en=1, g_in stepped through the Gray sequence 0000,0001,0011,0010 with b_ready=1 -> b_out=1,2,3, dir=1, step_err=0, each b_valid exactly 3 edges after its g_in change.
- Wrap: g_in 1000 (bin 15) -> 0000 (bin 0) -> b_out=0, dir=1, no error. Then 0000 -> 1000 -> b_out=15, dir=0, no error.
- Illegal jump: g_in 0000 -> 0110 (bin 4) -> b_out=4, step_err=1 with b_valid, err_cnt=1. A further 16+ ... (ERRW=2 build) jumps -> err_cnt holds at 3. clr_err -> 0.
- Backpressure: b_ready=0 while g_in moves bin 1->2->3 -> b_valid stays with b_out=1. Raise b_ready -> next event b_out=3, step_err=1 (delta=2).
- en=0 during HOLD -> handshake completes, then IDLE. Move g_in while idle, re-enable -> no event until the next change, which reports delta ±1 from the new baseline.
- Assert rst_n=0 asynchronously mid-HOLD -> b_valid, b_out, err_cnt drop to 0 before the next clk edge.
